// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - video/CPU arbiter for a single-port async SRAM, registered outputs.
// Optional starvation guard enabled by defining SRAM_ARB_STARVE_GUARD_EN.
module sram_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk_vga,
    input  logic        reset_wire,
    input  logic        vid_req,
    input  logic [20:0] vid_addr,
    output logic [7:0]  vid_rdata,
    output logic        vid_ack,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [20:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_ack,
    output logic [20:0] SRAM_ADDR,
    inout  wire  [7:0]  SRAM_DATA,
    output logic        SRAM_WE_n
);

    typedef enum logic [2:0] {
        IDLE, VRD1, VRD2, CRD1, CRD2, CWR1, CWR2, CWR3
    } state_t;

    state_t      state_q, state_d;
    logic [20:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  vid_rdata_q, vid_rdata_d;
    logic [7:0]  cpu_rdata_q, cpu_rdata_d;
    logic        vid_ack_q, vid_ack_d;
    logic        cpu_ack_q, cpu_ack_d;
    logic        we_n_q, we_n_d;
    logic        drive_q, drive_d;
    logic        cpu_force;
    logic        vid_grant;
    logic        cpu_grant;

    assign vid_grant = (state_q == IDLE) && vid_req && !cpu_force;
    assign cpu_grant = (state_q == IDLE) && cpu_req && !vid_grant;

`ifdef SRAM_ARB_STARVE_GUARD_EN
    localparam int CW = $clog2(STARVE_MAX + 1);
    logic [CW-1:0] starve_q, starve_d;

    // Counts video grants taken while the CPU was waiting.
    always_comb begin
        starve_d = starve_q;
        if (cpu_grant) begin
            starve_d = '0;
        end else if (vid_grant && cpu_req) begin
            starve_d = starve_q + CW'(1);
        end
    end

    always_ff @(posedge clk_vga or posedge reset_wire) begin
        if (reset_wire) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

    assign cpu_force = cpu_req && (starve_q == CW'(STARVE_MAX));
`else
    assign cpu_force = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        vid_rdata_d = vid_rdata_q;
        cpu_rdata_d = cpu_rdata_q;
        unique case (state_q)
            IDLE: begin
                if (vid_grant) begin
                    state_d = VRD1;
                    addr_d  = vid_addr;
                end else if (cpu_grant) begin
                    state_d = cpu_we ? CWR1 : CRD1;
                    addr_d  = cpu_addr;
                    wdata_d = cpu_wdata;
                end
            end
            VRD1: state_d = VRD2;
            VRD2: begin
                state_d     = IDLE;
                vid_rdata_d = SRAM_DATA;
            end
            CRD1: state_d = CRD2;
            CRD2: begin
                state_d     = IDLE;
                cpu_rdata_d = SRAM_DATA;
            end
            CWR1: state_d = CWR2;
            CWR2: state_d = CWR3;
            CWR3: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Strobes and acks are decoded from the upcoming state so they stay registered.
        vid_ack_d = (state_q == VRD2);
        cpu_ack_d = (state_q == CRD2) || (state_d == CWR3);
        we_n_d    = (state_d != CWR2);
        drive_d   = (state_d == CWR1) || (state_d == CWR2) || (state_d == CWR3);
    end

    always_ff @(posedge clk_vga or posedge reset_wire) begin
        if (reset_wire) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            vid_rdata_q <= '0;
            cpu_rdata_q <= '0;
            vid_ack_q   <= 1'b0;
            cpu_ack_q   <= 1'b0;
            we_n_q      <= 1'b1;
            drive_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            vid_rdata_q <= vid_rdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            vid_ack_q   <= vid_ack_d;
            cpu_ack_q   <= cpu_ack_d;
            we_n_q      <= we_n_d;
            drive_q     <= drive_d;
        end
    end

    assign SRAM_ADDR = addr_q;
    assign SRAM_WE_n = we_n_q;
    assign SRAM_DATA = drive_q ? wdata_q : 8'hzz;
    assign vid_rdata = vid_rdata_q;
    assign cpu_rdata = cpu_rdata_q;
    assign vid_ack   = vid_ack_q;
    assign cpu_ack   = cpu_ack_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - scoreboard bench for sram_arbiter with a simple SRAM model.
module tb_sram_arbiter;

    logic        clk_vga = 1'b0;
    logic        reset_wire = 1'b1;
    logic        vid_req = 1'b0;
    logic [20:0] vid_addr = '0;
    logic [7:0]  vid_rdata;
    logic        vid_ack;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [20:0] cpu_addr = '0;
    logic [7:0]  cpu_wdata = '0;
    logic [7:0]  cpu_rdata;
    logic        cpu_ack;
    logic [20:0] sram_addr;
    wire  [7:0]  sram_data;
    logic        sram_we_n;

    always #5 clk_vga = ~clk_vga;

    sram_arbiter #(.STARVE_MAX(4)) dut (
        .clk_vga(clk_vga), .reset_wire(reset_wire),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_rdata(vid_rdata), .vid_ack(vid_ack),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .SRAM_ADDR(sram_addr), .SRAM_DATA(sram_data), .SRAM_WE_n(sram_we_n)
    );

    // SRAM model: the bench stops driving while one of its own writes is outstanding.
    logic [7:0] mem [0:2097151];
    logic       mem_init = 1'b0;
    logic       wr_active = 1'b0;
    assign sram_data = wr_active ? 8'hzz : mem[sram_addr];

    always @(posedge clk_vga) begin
        if (!mem_init) begin
            mem[21'h00000] = 8'h3C;
            mem[21'h00010] = 8'h11;
            mem[21'h00020] = 8'h22;
            mem[21'h00030] = 8'h33;
            mem[21'h00040] = 8'h44;
            mem[21'h00100] = 8'h00;
            mem[21'h00200] = 8'h77;
            mem[21'h1ABCD] = 8'h5A;
            mem_init = 1'b1;
        end else if (!sram_we_n) begin
            mem[sram_addr] = sram_data;
        end
    end

    int cyc = 0;
    always @(posedge clk_vga) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        bit          is_vid;
        logic [7:0]  data;
        int          lat;
        logic [20:0] addr;
        bit          chk;
    } exp_t;
    exp_t exp_q[$];
    int vid_issue = 0;
    int cpu_issue = 0;

    task automatic push(input bit v, input logic [7:0] d, input int lat, input logic [20:0] a, input bit c);
        exp_t e;
        e.is_vid = v; e.data = d; e.lat = lat; e.addr = a; e.chk = c;
        exp_q.push_back(e);
    endtask

    // Monitor: every ack pops the next expectation, which also fixes the grant order.
    always @(negedge clk_vga) begin
        if (vid_ack || cpu_ack) begin
            if (vid_ack && cpu_ack) begin
                check("both_acks", 32'(1), 32'(0));
            end else if (exp_q.size() == 0) begin
                check("unexpected_ack", 32'({vid_ack, cpu_ack}), 32'(0));
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("grant_is_vid", 32'(vid_ack), 32'(e.is_vid));
                if (e.chk) begin
                    check("rdata", 32'(e.is_vid ? vid_rdata : cpu_rdata), 32'(e.data));
                    check("ack_addr", 32'(sram_addr), 32'(e.addr));
                end
                if (e.lat > 0)
                    check("ack_latency", 32'(cyc - (e.is_vid ? vid_issue : cpu_issue)), 32'(e.lat));
            end
        end
    end

    task automatic req_vid(input logic [20:0] a);
        bit seen = 0;
        vid_addr = a; vid_req = 1'b1; vid_issue = cyc;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk_vga);
            seen = vid_ack;
        end
        if (!seen) check("vid_timeout", 32'(0), 32'(1));
        vid_req = 1'b0;
    endtask

    task automatic req_cpu(input logic we, input logic [20:0] a, input logic [7:0] d);
        bit seen = 0;
        cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_req = 1'b1; cpu_issue = cyc;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk_vga);
            seen = cpu_ack;
        end
        if (!seen) check("cpu_timeout", 32'(0), 32'(1));
        cpu_req = 1'b0;
    endtask

    initial begin
        int acks;
        int t_drop;
        bit seen;

        repeat (2) @(negedge clk_vga);
        check("rst_we_n", 32'(sram_we_n), 32'(1));
        check("rst_addr", 32'(sram_addr), 32'(0));
        check("rst_acks", 32'({vid_ack, cpu_ack}), 32'(0));
        check("rst_rdata", 32'({vid_rdata, cpu_rdata}), 32'(0));
        reset_wire = 1'b0;
        @(negedge clk_vga);

        // Simultaneous first requests: video then CPU.
        push(1, 8'h11, 3, 21'h00010, 1);
        push(0, 8'h22, 6, 21'h00020, 1);
        fork
            req_vid(21'h00010);
            req_cpu(1'b0, 21'h00020, 8'h00);
        join
        @(negedge clk_vga);

        push(0, 8'h5A, 3, 21'h1ABCD, 1);
        req_cpu(1'b0, 21'h1ABCD, 8'h00);
        check("vid_rdata_held", 32'(vid_rdata), 32'(8'h11));
        @(negedge clk_vga);

        // CPU write with per-cycle strobe/data checks.
        push(0, 8'h00, 3, 21'h00100, 0);
        wr_active = 1'b1;
        cpu_we = 1'b1; cpu_addr = 21'h00100; cpu_wdata = 8'hC3; cpu_req = 1'b1; cpu_issue = cyc;
        @(negedge clk_vga);
        check("cwr1_we_n", 32'(sram_we_n), 32'(1));
        check("cwr1_data", 32'(sram_data), 32'(8'hC3));
        check("cwr1_addr", 32'(sram_addr), 32'(21'h00100));
        @(negedge clk_vga);
        check("cwr2_we_n", 32'(sram_we_n), 32'(0));
        check("cwr2_data", 32'(sram_data), 32'(8'hC3));
        @(negedge clk_vga);
        check("cwr3_we_n", 32'(sram_we_n), 32'(1));
        check("cwr3_data", 32'(sram_data), 32'(8'hC3));
        check("cwr3_ack", 32'(cpu_ack), 32'(1));
        cpu_req = 1'b0;
        @(negedge clk_vga);
        check("post_wr_we_n", 32'(sram_we_n), 32'(1));
        wr_active = 1'b0;
        @(negedge clk_vga);
        push(0, 8'hC3, 3, 21'h00100, 1);
        req_cpu(1'b0, 21'h00100, 8'h00);
        @(negedge clk_vga);

        // Contention: both requests held continuously.
        vid_addr = 21'h00030; cpu_addr = 21'h00040; cpu_we = 1'b0;
`ifdef SRAM_ARB_STARVE_GUARD_EN
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 4; k++) push(1, 8'h33, 0, 21'h00030, 1);
            push(0, 8'h44, 0, 21'h00040, 1);
        end
        vid_req = 1'b1; cpu_req = 1'b1;
        acks = 0;
        for (int i = 0; i < 100 && acks < 10; i++) begin
            @(negedge clk_vga);
            if (vid_ack || cpu_ack) acks++;
        end
        check("contention_acks", 32'(acks), 32'(10));
        vid_req = 1'b0; cpu_req = 1'b0;
`else
        for (int k = 0; k < 6; k++) push(1, 8'h33, 0, 21'h00030, 1);
        vid_req = 1'b1; cpu_req = 1'b1;
        acks = 0;
        for (int i = 0; i < 100 && acks < 6; i++) begin
            @(negedge clk_vga);
            if (vid_ack || cpu_ack) acks++;
        end
        check("contention_acks", 32'(acks), 32'(6));
        push(0, 8'h44, 0, 21'h00040, 1);
        vid_req = 1'b0;
        t_drop = cyc;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk_vga);
            seen = cpu_ack;
        end
        check("cpu_after_vid_drop", 32'(seen && (cyc - t_drop) <= 4), 32'(1));
        cpu_req = 1'b0;
`endif
        @(negedge clk_vga);

        // Reset asserted in CWR2 aborts the write.
        wr_active = 1'b1;
        cpu_we = 1'b1; cpu_addr = 21'h00200; cpu_wdata = 8'hC3; cpu_req = 1'b1;
        @(negedge clk_vga);
        @(negedge clk_vga);
        check("abort_cwr2_we_low", 32'(sram_we_n), 32'(0));
        #1 reset_wire = 1'b1;
        #1;
        check("abort_we_n", 32'(sram_we_n), 32'(1));
        check("abort_addr", 32'(sram_addr), 32'(0));
        check("abort_cpu_rdata", 32'(cpu_rdata), 32'(0));
        cpu_req = 1'b0;
        wr_active = 1'b0;
        #1;
        check("abort_data_released", 32'(sram_data), 32'(8'h3C));
        repeat (2) @(negedge clk_vga);
        check("abort_no_write", 32'(mem[21'h00200]), 32'(8'h77));
        reset_wire = 1'b0;
        @(negedge clk_vga);
        push(1, 8'h3C, 3, 21'h00000, 1);
        req_vid(21'h00000);

        repeat (4) @(negedge clk_vga);
        check("scoreboard_drained", 32'(exp_q.size()), 32'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter: STARVE_MAX, default 4, maximum consecutive video grants while a CPU request is pending.
REQ-002 Port: clk_vga  input  1  clock; all state updates on rising edge.
REQ-003 Port: reset_wire  input  1  reset, asynchronous, active-high.
REQ-004 Port: vid_req  input  1  video fetch request; level, held until vid_ack.
REQ-005 Port: vid_addr  input  21  video byte address; stable while vid_req high.
REQ-006 Port: vid_rdata  output  8  video read data; valid in the vid_ack cycle and held until the next video read completes.
REQ-007 Port: vid_ack  output  1  one-cycle pulse marking video read completion.
REQ-008 Port: cpu_req  input  1  CPU/chipset request; level, held until cpu_ack.
REQ-009 Port: cpu_we  input  1  1 = write, 0 = read; stable while cpu_req high.
REQ-010 Port: cpu_addr  input  21  CPU byte address; stable while cpu_req high.
REQ-011 Port: cpu_wdata  input  8  write data; stable while cpu_req high.
REQ-012 Port: cpu_rdata  output  8  CPU read data; valid in the cpu_ack cycle and held until the next CPU read completes.
REQ-013 Port: cpu_ack  output  1  one-cycle pulse marking CPU access completion.
REQ-014 Port: SRAM_ADDR  output  21  registered SRAM address.
REQ-015 Port: SRAM_DATA  inout  8  SRAM data; driven only in write states, otherwise high-Z.
REQ-016 Port: SRAM_WE_n  output  1  registered write strobe, active-low.

Function
REQ-017 States: IDLE, VRD1, VRD2, CRD1, CRD2, CWR1, CWR2, CWR3; all outputs registered.
REQ-018 IDLE arbitration: vid_req wins over cpu_req unless the starvation guard forces CPU (REQ-027); an idle cycle with no request stays in IDLE.
REQ-019 Grant cycle: SRAM_ADDR loads the winner's address as IDLE goes to VRD1, CRD1 or CWR1.
REQ-020 Read sequencing: in xRD1 the address is stable; in xRD2 SRAM_DATA is sampled into vid_rdata or cpu_rdata and the matching ack pulses.
REQ-021 Read latency: ack appears 3 cycles after IDLE samples the request (grant, RD1, RD2).
REQ-022 Write sequencing:
- CWR1: drive cpu_wdata, SRAM_WE_n=1.
- CWR2: SRAM_WE_n=0.
- CWR3: SRAM_WE_n=1, data still driven; cpu_ack pulses.
REQ-023 After any ack state, the FSM returns to IDLE; back-to-back accesses therefore have one IDLE arbitration cycle between them.
REQ-024 Requester ownership: a requester that drops its request before ack is a protocol violation; the access in flight still completes and acks.
REQ-025 SRAM_ADDR holds its last value in IDLE; SRAM_DATA is released (high-Z) in every state except CWR1..CWR3.
REQ-026 Requests arriving mid-access are not lost; they are evaluated at the next IDLE.
REQ-027 Starvation guard: a counter increments on each video grant made while cpu_req is high and clears on any CPU grant; when it equals STARVE_MAX and cpu_req is high, CPU wins.
REQ-028 Simultaneous first requests from reset: the video access is served first, then the CPU access.

Reset
REQ-029 While reset_wire is high, or on its assertion mid-access, the block goes immediately to:
- FSM = IDLE; SRAM_WE_n=1; SRAM_DATA high-Z; SRAM_ADDR=0.
- vid_ack=0, cpu_ack=0; vid_rdata=0, cpu_rdata=0; starvation counter=0.
REQ-030 An access aborted by reset is never acked; the requester re-requests after reset.

Configuration
REQ-031 Macro SRAM_ARB_STARVE_GUARD_EN:
- Defined: the starvation guard of REQ-027 is active.
- Undefined: the counter is absent and arbitration is strict video priority (CPU served only when vid_req is low in IDLE).

Verification
REQ-032 CPU read only: mem[0x1ABCD]=0x5A, cpu_req pulse-held -> SRAM_ADDR=0x1ABCD, cpu_rdata=0x5A, cpu_ack exactly 3 cycles after request sampled.
REQ-033 CPU write: addr 0x00100, data 0xC3 -> WE_n low exactly one cycle (CWR2), data driven CWR1..CWR3, readback 0xC3.
REQ-034 Contention with guard defined: vid_req and cpu_req held continuously -> grant order V,V,V,V,C repeating.
REQ-035 Contention with guard undefined: same stimulus -> CPU never acked while vid_req high; acked within 4 cycles after vid_req drops.
REQ-036 Reset during CWR2 -> WE_n=1 and data high-Z immediately, no cpu_ack; post-reset video read of 0x00000 -> vid_ack in 3 cycles.
